dff_prim_bank: RTL and testbench

//  Bank of primitive flip-flops used by the reset-synchroniser and glitch-catch logic.

---
 rtl/dff_prim_bank.sv | 41 ++++
 tb/tb_dff_prim_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dff_prim_bank.sv
// Bank of primitive flops: WIDTH plain D flops and WIDTH D flops with an asynchronous
// active-high set. All flops share one clock and one synchronous active-low reset.
module dff_prim_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] ds,
  output logic [WIDTH-1:0] qs
);

  // plain re-timing / synchroniser lanes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  // glitch-catch lanes: set is an asynchronous preset so it must stay in the sensitivity list
  for (genvar i = 0; i < WIDTH; i++) begin : g_as
    logic qs_r;

    always_ff @(posedge clk or posedge set[i]) begin
      if (set[i]) begin
        qs_r <= 1'b1;
      end else if (!rst_n) begin
        qs_r <= 1'b0;
      end else begin
        qs_r <= ds[i];
      end
    end

    assign qs[i] = qs_r;
  end

endmodule

// File: tb/tb_dff_prim_bank.sv
// Randomised scoreboard bench for dff_prim_bank: stimulus pushes model predictions,
// a monitor process pops and compares them against the DUT outputs.
module tb_dff_prim_bank;
  localparam int WIDTH = 4;

  logic             clk;
  logic             clk_en;
  logic             rst_n;
  logic [WIDTH-1:0] d, ds, set;
  logic [WIDTH-1:0] d_t, ds_t;
  logic [WIDTH-1:0] q, qs;
  logic             chain;
  logic             done = 1'b0;

  dff_prim_bank #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .q    (q),
    .set  (set),
    .ds   (ds),
    .qs   (qs)
  );

  // external chain wiring: ds[1]=qs[0], d[0]=qs[1], d[1]=q[0]
  always_comb begin
    d  = d_t;
    ds = ds_t;
    if (chain) begin
      ds[1] = qs[0];
      d[0]  = qs[1];
      d[1]  = q[0];
    end
  end

  initial begin
    clk    = 1'b0;
    clk_en = 1'b1;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  // reference model state (X until the first reset edge)
  logic [WIDTH-1:0] mq, mqs;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qs;
    string            name;
  } exp_t;

  exp_t sbq[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // model of one rising clock edge, using pre-edge inputs and pre-edge model outputs
  task automatic model_edge();
    logic [WIDTH-1:0] ed, eds;
    ed  = d_t;
    eds = ds_t;
    if (chain) begin
      eds[1] = mqs[0];
      ed[0]  = mqs[1];
      ed[1]  = mq[0];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (set[i])      mqs[i] = 1'b1;
      else if (!rst_n) mqs[i] = 1'b0;
      else             mqs[i] = eds[i];
    end
    mq = rst_n ? ed : '0;
  endtask

  // drive set; any rising bit forces its model output to 1 immediately
  task automatic set_now(input logic [WIDTH-1:0] v);
    set = v;
    mqs = mqs | v;
  endtask

  task automatic push(input string name);
    exp_t e;
    e.q    = mq;
    e.qs   = mqs;
    e.name = name;
    sbq.push_back(e);
    ->sample_ev;
  endtask

  task automatic edge_and_check(input string name);
    @(posedge clk);
    model_edge();
    #1;
    push(name);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if (q !== e.q || qs !== e.qs) begin
          errors++;
          $display("FAIL %s: got q=%b qs=%b expected q=%b qs=%b", e.name, q, qs, e.q, e.qs);
        end
      end
    end
  end

  // watchdog: stimulus must complete within the time bound
  initial begin
    #100000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete, expired wait");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    logic [WIDTH-1:0] nset, gbit;
    logic [3:0]       pat [3];
    chain = 1'b0;
    mq    = 'x;
    mqs   = 'x;
    set   = '0;
    rst_n = 1'b0;
    d_t   = 4'hF;
    ds_t  = 4'hF;
    edge_and_check("reset");
    checks++;
    if (q !== '0 || qs !== '0) begin
      errors++;
      $display("FAIL reset_state: got q=%b qs=%b expected q=0000 qs=0000", q, qs);
    end

    @(negedge clk);
    rst_n = 1'b1;
    edge_and_check("reset_release");

    pat[0] = 4'h5; pat[1] = 4'hA; pat[2] = 4'h3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d_t  = pat[k];
      ds_t = ~pat[k];
      edge_and_check("pipeline");
    end

    // async set with the clock stopped low
    @(negedge clk);
    clk_en = 1'b0;
    ds_t   = 4'h0;
    #2;
    set_now(4'b0001);
    #1;
    push("async_set_no_clk");
    #1;
    set_now(4'b0000);
    #1;
    push("async_set_held");
    #3;
    push("async_set_still_held");
    clk_en = 1'b1;
    edge_and_check("set_release_edge");

    // set beats reset on lane 2
    @(negedge clk);
    rst_n = 1'b0;
    d_t   = 4'hF;
    ds_t  = 4'hF;
    set_now(4'b0100);
    for (int k = 0; k < 3; k++) edge_and_check("set_priority");
    @(negedge clk);
    set_now(4'b0000);
    rst_n = 1'b1;
    edge_and_check("priority_release");

    // randomised phase: random data, occasional resets, held sets and narrow glitches
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      d_t   = WIDTH'($urandom);
      ds_t  = WIDTH'($urandom);
      rst_n = ($urandom_range(0, 15) != 0);
      nset  = '0;
      for (int i = 0; i < WIDTH; i++) nset[i] = ($urandom_range(0, 7) == 0);
      set_now(nset);
      if ($urandom_range(0, 3) == 0) begin
        gbit = '0;
        gbit[$urandom_range(0, WIDTH - 1)] = 1'b1;
        gbit = gbit & ~set;
        #1;
        set_now(set | gbit);
        #1;
        push("glitch_rise");
        set_now(set & ~gbit);
        #1;
        push("glitch_fall");
      end
      edge_and_check("random");
    end

    // chain: qs[0] -> qs[1] -> q[0] -> q[1]
    @(negedge clk);
    set_now('0);
    rst_n = 1'b1;
    d_t   = '0;
    ds_t  = '0;
    chain = 1'b1;
    for (int k = 0; k < 4; k++) edge_and_check("chain_flush");
    @(negedge clk);
    #2;
    set_now(4'b0001);
    #1;
    set_now(4'b0000);
    #1;
    push("chain_glitch");
    for (int k = 0; k < 6; k++) edge_and_check("chain");

    #2;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0 && checks > 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
